// File: rtl/counter_2_bit_pkg.sv
`timescale 1ns/1ps
// counter_2_bit_pkg
// Shared constants and types for the 2-bit free-running counter.
//   CNT_W   : counter width (fixed at 2)
//   cnt_t   : counter value type
//   CNT_RST : value loaded by reset
//   CNT_MAX : terminal count value, decoded onto tc
package counter_2_bit_pkg;

  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_RST = 2'b00;
  localparam cnt_t CNT_MAX = 2'b11;

endpackage

// File: rtl/counter_2_bit_inc.sv
`timescale 1ns/1ps
// counter_2_bit_inc
// Combinational next-state function of the counter: adds one modulo 4.
// Ports:
//   cnt      in   current count
//   cnt_next out  (cnt + 1) mod 4
module counter_2_bit_inc
  import counter_2_bit_pkg::*;
(
  input  cnt_t cnt,
  output cnt_t cnt_next
);

  // The sum is kept at counter width, so the carry out of 3 + 1 is dropped
  // and the count wraps to 0 on its own.
  assign cnt_next = cnt + cnt_t'(1);

endmodule

// File: rtl/counter_2_bit.sv
`timescale 1ns/1ps
// counter_2_bit
// Free-running 2-bit binary up-counter with a terminal-count decode.
// Ports:
//   clk    in   1  clock, state updates on the rising edge
//   reset  in   1  asynchronous active-high reset, clears q immediately
//   q      out  2  registered count, 0 -> 1 -> 2 -> 3 -> 0 ...
//   tc     out  1  high exactly while q == 3 (combinational from q)
// Configuration:
//   COUNTER_2_BIT_ASSERT_EN  when defined, simulation-only consistency checks
//                            are compiled in; ports and behaviour are unchanged.
module counter_2_bit
  import counter_2_bit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] q,
  output logic             tc
);

  cnt_t cnt_next;

  counter_2_bit_inc u_inc (
    .cnt      (q),
    .cnt_next (cnt_next)
  );

  // The count register drives q directly. A reset still high on a clock edge
  // wins, so a release coincident with an edge holds 0 for that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= CNT_RST;
    end else begin
      q <= cnt_next;
    end
  end

  assign tc = (q == CNT_MAX);

`ifdef COUNTER_2_BIT_ASSERT_EN
  // History of the count and of reset as seen on each rising edge, used to
  // check every step once the counter has been running for two edges.
  cnt_t prev_q;
  logic rst_at_edge;
  logic rst_at_prev_edge;

  always @(posedge clk) begin
    prev_q           <= q;
    rst_at_edge      <= reset;
    rst_at_prev_edge <= rst_at_edge;
  end

  // Checks are evaluated mid-cycle so they never race the register update.
  always @(negedge clk) begin
    if (reset) begin
      assert (q == CNT_RST)
        else $error("%0t: q=%0d while reset is high", $time, q);
    end
    if (!reset && rst_at_edge === 1'b0 && rst_at_prev_edge === 1'b0) begin
      assert (q == cnt_t'(prev_q + cnt_t'(1)))
        else $error("%0t: q=%0d after previous q=%0d", $time, q, prev_q);
    end
    assert (tc == (q == CNT_MAX))
      else $error("%0t: tc=%0b with q=%0d", $time, tc, q);
  end
`endif

endmodule

// File: tb/tb_counter_2_bit.sv
`timescale 1ns/1ps
// tb_counter_2_bit
// Self-checking bench for counter_2_bit: a vector table drives reset per
// cycle and carries the expected count; expectations go into a scoreboard
// queue when stimulus is applied and are popped when outputs are sampled.
module tb_counter_2_bit;

  typedef struct {
    logic       rst;
    logic [1:0] q;
    logic       tc;
  } vec_t;

  typedef struct {
    logic [1:0] q;
    logic       tc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] q;
  logic       tc;

  int testsRun;
  int testsFailed;
  exp_t expQueue[$];

  counter_2_bit dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .tc    (tc)
  );

  // Rising edges at 5, 15, 25 ... ns; outputs are sampled on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pushes an expectation onto the scoreboard.
  task automatic pushExpect(input logic [1:0] eq, input logic etc);
    exp_t e;
    e.q  = eq;
    e.tc = etc;
    expQueue.push_back(e);
  endtask

  // Drives reset for the coming cycle and records what the DUT should show.
  task automatic applyStimulus(input logic rst, input logic [1:0] eq, input logic etc);
    reset = rst;
    pushExpect(eq, etc);
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs.
  task automatic checkOutput(input string name);
    exp_t e;
    testsRun++;
    if (expQueue.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: no expectation queued (q=%0d tc=%0b) at %0t", name, q, tc, $time);
    end else begin
      e = expQueue.pop_front();
      if (q !== e.q || tc !== e.tc) begin
        testsFailed++;
        $display("[TB] FAIL %s: got q=%0d tc=%0b, expected q=%0d tc=%0b at %0t",
                 name, q, tc, e.q, e.tc, $time);
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Free count after power-up release, then in-table reset cycles.
    vecs = '{
      '{1'b0, 2'd1, 1'b0}, '{1'b0, 2'd2, 1'b0}, '{1'b0, 2'd3, 1'b1},
      '{1'b0, 2'd0, 1'b0}, '{1'b0, 2'd1, 1'b0}, '{1'b0, 2'd2, 1'b0},
      '{1'b0, 2'd3, 1'b1}, '{1'b0, 2'd0, 1'b0}, '{1'b0, 2'd1, 1'b0},
      '{1'b1, 2'd0, 1'b0}, '{1'b1, 2'd0, 1'b0}, '{1'b0, 2'd1, 1'b0},
      '{1'b0, 2'd2, 1'b0}, '{1'b0, 2'd3, 1'b1}, '{1'b1, 2'd0, 1'b0},
      '{1'b0, 2'd1, 1'b0}, '{1'b0, 2'd2, 1'b0}
    };

    // Power-up reset from 0 to 10 ns, with the rising edge at 5 ns inside.
    reset = 1'b1;
    pushExpect(2'd0, 1'b0);
    #1;
    checkOutput("powerup_async");
    pushExpect(2'd0, 1'b0);
    @(negedge clk);
    checkOutput("powerup_after_edge");

    // Table: reset applied at a falling edge, result sampled one cycle later.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        applyStimulus(1'b1, 2'd0, 1'b0);
        #1;
        checkOutput($sformatf("vec%0d_async", i));
        pushExpect(vecs[i].q, vecs[i].tc);
      end else begin
        applyStimulus(1'b0, vecs[i].q, vecs[i].tc);
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i));
    end

    // Mid-count pulse: q is 2 here; a 2 ns reset between edges clears it
    // without a clock, and the next edge after release gives 1.
    #1;
    applyStimulus(1'b1, 2'd0, 1'b0);
    #1;
    checkOutput("midcount_clear");
    #1;
    applyStimulus(1'b0, 2'd0, 1'b0);
    #1;
    checkOutput("midcount_hold_until_edge");
    pushExpect(2'd1, 1'b0);
    @(negedge clk);
    checkOutput("midcount_first_edge");

    // Release landing on a rising edge: that edge keeps 0, the next gives 1.
    applyStimulus(1'b1, 2'd0, 1'b0);
    @(posedge clk);
    #0.001;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("edge_release_hold");
    pushExpect(2'd1, 1'b0);
    @(negedge clk);
    checkOutput("edge_release_first");
    pushExpect(2'd2, 1'b0);
    @(negedge clk);
    checkOutput("edge_release_second");
    pushExpect(2'd3, 1'b1);
    @(negedge clk);
    checkOutput("edge_release_tc");
    pushExpect(2'd0, 1'b0);
    @(negedge clk);
    checkOutput("edge_release_wrap");

    if (expQueue.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", expQueue.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
